sync_fifo_ext: RTL and testbench

- Parametrised synchronous FIFO for the I2C datapath (TX/RX byte buffering between the register interface and the byte engine).
- Adds the following over the single-mode FIFO:
  - selectable standard or first-word-fall-through read mode;
  - exact registered flags;
  - programmable almost-full and almost-empty thresholds;
  - fill level output;
  - synchronous flush;
  - sticky overflow and underflow error flags.

---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/fifo_ram.sv | 25 ++
 rtl/sync_fifo_ext.sv | 132 +++++++++++++
 tb/tb_sync_fifo_ext.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and parameter validation for the extended synchronous FIFO.
package sync_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic bit fifo_params_ok(input int depth, input int ptr_w,
                                          input int afull_th, input int aempty_th,
                                          input int fwft);
        bit ok;
        ok = (depth >= 2) && ((depth & (depth - 1)) == 0);
        ok = ok && (ptr_w == $clog2(depth));
        ok = ok && (afull_th >= 1) && (afull_th <= depth);
        ok = ok && (aempty_th >= 0) && (aempty_th <= depth - 1);
        ok = ok && ((fwft == FIFO_STD) || (fwft == FIFO_FWFT));
        return ok;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with standard/FWFT read modes, registered flags, thresholds,
// fill level, flush and sticky error flags.
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = $clog2(FIFO_DEPTH),
    parameter int AFULL_TH   = FIFO_DEPTH - 4,
    parameter int AEMPTY_TH  = 4,
    parameter int FWFT       = FIFO_STD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  clear_err,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_W:0]        level,
    output logic                  overflow,
    output logic                  underflow
);

    if (!fifo_params_ok(FIFO_DEPTH, PTR_W, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_bad_params
        $error("sync_fifo_ext: illegal FIFO_DEPTH/PTR_W/threshold/FWFT parameters");
    end

    localparam logic [PTR_W:0] DEPTH_L  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] AFULL_L  = (PTR_W+1)'(AFULL_TH);
    localparam logic [PTR_W:0] AEMPTY_L = (PTR_W+1)'(AEMPTY_TH);

    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]        level_q, level_d;
    logic                  empty_q, empty_d, full_q, full_d;
    logic                  afull_q, afull_d, aempty_q, aempty_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;
    logic                  rd_acc, wr_acc, mem_we;
    logic [DATA_WIDTH-1:0] rdata;

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .AW         (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (head_q),
        .wdata (data_in),
        .raddr (tail_q),
        .rdata (rdata)
    );

    always_comb begin
        rd_acc   = read_en && !empty_q;
        wr_acc   = write_en && (!full_q || rd_acc);
        mem_we   = 1'b0;
        head_d   = head_q;
        tail_d   = tail_q;
        level_d  = level_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        ovf_d    = ovf_q && !clear_err;
        udf_d    = udf_q && !clear_err;
        // Flush wins over both requests and suppresses error detection.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            mem_we   = wr_acc;
            head_d   = wr_acc ? head_q + 1'b1 : head_q;
            tail_d   = rd_acc ? tail_q + 1'b1 : tail_q;
            level_d  = level_q + {{PTR_W{1'b0}}, wr_acc} - {{PTR_W{1'b0}}, rd_acc};
            dout_d   = rd_acc ? rdata : dout_q;
            dvalid_d = rd_acc;
            ovf_d    = ovf_d || (write_en && !wr_acc);
            udf_d    = udf_d || (read_en && !rd_acc);
        end
        empty_d  = (level_d == '0);
        full_d   = (level_d == DEPTH_L);
        afull_d  = (level_d >= AFULL_L);
        aempty_d = (level_d <= AEMPTY_L);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign data_out     = (FWFT == FIFO_FWFT) ? (empty_q ? '0 : rdata) : dout_q;
    assign data_valid   = (FWFT == FIFO_FWFT) ? !empty_q : dvalid_q;
    assign fifo_empty   = empty_q;
    assign fifo_full    = full_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: a standard-mode and an FWFT-mode instance share one
// stimulus stream and are compared against a queue-based reference model.
module tb_sync_fifo_ext;

    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int AFULL  = DEPTH - 4;
    localparam int AEMPTY = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, clear_err, write_en, read_en;
    logic [DW-1:0] data_in;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_dv, s_emp, s_ful, s_af, s_ae, s_ovf, s_udf;
    logic          f_dv, f_emp, f_ful, f_af, f_ae, f_ovf, f_udf;
    logic [4:0]    s_lvl, f_lvl;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sync_fifo_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AFULL_TH(AFULL),
                    .AEMPTY_TH(AEMPTY), .FWFT(0)) dut_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clear_err(clear_err),
        .write_en(write_en), .data_in(data_in), .read_en(read_en),
        .data_out(s_dout), .data_valid(s_dv), .fifo_empty(s_emp), .fifo_full(s_ful),
        .almost_full(s_af), .almost_empty(s_ae), .level(s_lvl),
        .overflow(s_ovf), .underflow(s_udf));

    sync_fifo_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AFULL_TH(AFULL),
                    .AEMPTY_TH(AEMPTY), .FWFT(1)) dut_fw (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clear_err(clear_err),
        .write_en(write_en), .data_in(data_in), .read_en(read_en),
        .data_out(f_dout), .data_valid(f_dv), .fifo_empty(f_emp), .fifo_full(f_ful),
        .almost_full(f_af), .almost_empty(f_ae), .level(f_lvl),
        .overflow(f_ovf), .underflow(f_udf));

    logic [19:0] vec_std, vec_fw;
    assign vec_std = {s_lvl, s_emp, s_ful, s_af, s_ae, s_ovf, s_udf, s_dout, s_dv};
    assign vec_fw  = {f_lvl, f_emp, f_ful, f_af, f_ae, f_ovf, f_udf, f_dout, f_dv};

    // Reference model: stored words, sticky errors, standard-mode output register.
    logic [DW-1:0] mq[$];
    bit            m_ovf, m_udf, m_dv;
    logic [DW-1:0] m_dout;

    task automatic model_update(input logic rst, we, input logic [DW-1:0] din,
                                input logic re, fl, ce);
        bit was_empty, was_full, rd_ok, wr_ok;
        if (!rst) begin
            mq.delete(); m_ovf = 0; m_udf = 0; m_dv = 0; m_dout = '0;
        end else if (fl) begin
            mq.delete(); m_dv = 0;
            if (ce) begin m_ovf = 0; m_udf = 0; end
        end else begin
            was_empty = (mq.size() == 0);
            was_full  = (mq.size() == DEPTH);
            rd_ok = re && !was_empty;
            wr_ok = we && (!was_full || rd_ok);
            if (rd_ok) m_dout = mq.pop_front();
            m_dv = rd_ok;
            if (wr_ok) mq.push_back(din);
            m_ovf = (m_ovf && !ce) || (we && !wr_ok);
            m_udf = (m_udf && !ce) || (re && !rd_ok);
        end
    endtask

    function automatic logic [19:0] exp_vec(input bit fw);
        int n;
        logic [DW-1:0] d;
        logic v;
        n = mq.size();
        if (fw) begin
            d = (n == 0) ? '0 : mq[0];
            v = (n != 0);
        end else begin
            d = m_dout;
            v = m_dv;
        end
        return {5'(n), n == 0, n == DEPTH, n >= AFULL, n <= AEMPTY, m_ovf, m_udf, d, v};
    endfunction

    // Drive one cycle of inputs, advance the model on the edge, return at negedge.
    task automatic step(input logic rst, we, input logic [DW-1:0] din,
                        input logic re, fl, ce);
        rst_n = rst; write_en = we; data_in = din; read_en = re; flush = fl; clear_err = ce;
        @(posedge clk);
        model_update(rst, we, din, re, fl, ce);
        @(negedge clk);
        rst_n = 1'b1; write_en = 1'b0; read_en = 1'b0; flush = 1'b0; clear_err = 1'b0;
    endtask

    task automatic test_reset;
        step(0, 1, 8'hEE, 1, 0, 0);
        n_checks++;
        if (vec_std !== 20'b00000_1_0_0_1_0_0_00000000_0)
            $display("FAIL reset_std: got %h want %h", vec_std, 20'b00000_1_0_0_1_0_0_00000000_0);
        else n_pass++;
        n_checks++;
        if (vec_fw !== 20'b00000_1_0_0_1_0_0_00000000_0)
            $display("FAIL reset_fw: got %h want %h", vec_fw, 20'b00000_1_0_0_1_0_0_00000000_0);
        else n_pass++;
    endtask

    task automatic test_fill_overflow;
        step(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 1, 8'(8'h10 + i), 0, 0, 0);
            n_checks++;
            if (s_lvl !== 5'(i) || s_af !== (i >= 12) || s_ful !== (i == 16) || s_emp !== 1'b0)
                $display("FAIL fill_%0d: lvl=%0d af=%b full=%b empty=%b want lvl=%0d af=%b full=%b empty=0",
                         i, s_lvl, s_af, s_ful, s_emp, i, (i >= 12), (i == 16));
            else n_pass++;
        end
        step(1, 1, 8'h99, 0, 0, 0);
        n_checks++;
        if (s_ovf !== 1'b1 || s_lvl !== 5'd16 || f_ovf !== 1'b1)
            $display("FAIL overflow_17th: ovf=%b/%b lvl=%0d want ovf=1/1 lvl=16", s_ovf, f_ovf, s_lvl);
        else n_pass++;
    endtask

    task automatic test_std_read;
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 8'hA5, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        n_checks++;
        if (s_dout !== 8'hA5 || s_dv !== 1'b1 || s_emp !== 1'b1)
            $display("FAIL std_read: dout=%h dv=%b empty=%b want dout=a5 dv=1 empty=1", s_dout, s_dv, s_emp);
        else n_pass++;
        step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (s_dv !== 1'b0 || s_dout !== 8'hA5)
            $display("FAIL std_pulse: dv=%b dout=%h want dv=0 dout=a5", s_dv, s_dout);
        else n_pass++;
    endtask

    task automatic test_fwft;
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 8'h3C, 0, 0, 0);
        n_checks++;
        if (f_dout !== 8'h3C || f_dv !== 1'b1)
            $display("FAIL fwft_show: dout=%h dv=%b want dout=3c dv=1", f_dout, f_dv);
        else n_pass++;
        step(1, 0, 0, 1, 0, 0);
        n_checks++;
        if (f_emp !== 1'b1 || f_dv !== 1'b0 || f_dout !== 8'h00)
            $display("FAIL fwft_pop: empty=%b dv=%b dout=%h want empty=1 dv=0 dout=00", f_emp, f_dv, f_dout);
        else n_pass++;
    endtask

    task automatic test_full_rw;
        logic [DW-1:0] want;
        step(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= DEPTH; i++) step(1, 1, 8'(8'h10 + i), 0, 0, 0);
        step(1, 1, 8'h77, 1, 0, 0);
        n_checks++;
        if (s_lvl !== 5'd16 || s_ovf !== 1'b0 || s_dout !== 8'h11 || s_dv !== 1'b1)
            $display("FAIL full_rw: lvl=%0d ovf=%b dout=%h dv=%b want lvl=16 ovf=0 dout=11 dv=1",
                     s_lvl, s_ovf, s_dout, s_dv);
        else n_pass++;
        for (int k = 0; k < DEPTH; k++) begin
            want = (k == DEPTH - 1) ? 8'h77 : 8'(8'h12 + k);
            n_checks++;
            if (f_dout !== want)
                $display("FAIL wrap_fw_%0d: dout=%h want %h", k, f_dout, want);
            else n_pass++;
            step(1, 0, 0, 1, 0, 0);
            n_checks++;
            if (s_dout !== want)
                $display("FAIL wrap_std_%0d: dout=%h want %h", k, s_dout, want);
            else n_pass++;
        end
        n_checks++;
        if (s_emp !== 1'b1 || s_udf !== 1'b0)
            $display("FAIL wrap_end: empty=%b udf=%b want empty=1 udf=0", s_emp, s_udf);
        else n_pass++;
    endtask

    task automatic test_empty_rw;
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 8'h55, 1, 0, 0);
        n_checks++;
        if (s_udf !== 1'b1 || s_lvl !== 5'd1 || s_dv !== 1'b0 || f_dout !== 8'h55)
            $display("FAIL empty_rw: udf=%b lvl=%0d dv=%b fw_dout=%h want udf=1 lvl=1 dv=0 fw_dout=55",
                     s_udf, s_lvl, s_dv, f_dout);
        else n_pass++;
        step(1, 0, 0, 0, 0, 1);
        n_checks++;
        if (s_udf !== 1'b0 || f_udf !== 1'b0 || s_lvl !== 5'd1)
            $display("FAIL clear_err: udf=%b/%b lvl=%0d want udf=0/0 lvl=1", s_udf, f_udf, s_lvl);
        else n_pass++;
    endtask

    task automatic test_flush;
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= DEPTH; i++) step(1, 1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 0, 0);
        n_checks++;
        if (s_lvl !== 5'd9 || s_ovf !== 1'b1)
            $display("FAIL pre_flush: lvl=%0d ovf=%b want lvl=9 ovf=1", s_lvl, s_ovf);
        else n_pass++;
        step(1, 1, 8'hBD, 1, 1, 0);
        n_checks++;
        if (s_lvl !== 5'd0 || s_emp !== 1'b1 || s_ovf !== 1'b1 || s_udf !== 1'b0 || s_dv !== 1'b0)
            $display("FAIL flush: lvl=%0d empty=%b ovf=%b udf=%b dv=%b want 0 1 1 0 0",
                     s_lvl, s_emp, s_ovf, s_udf, s_dv);
        else n_pass++;
        step(1, 1, 8'h42, 0, 0, 0);
        n_checks++;
        if (s_lvl !== 5'd1 || f_dout !== 8'h42)
            $display("FAIL post_flush_wr: lvl=%0d fw_dout=%h want lvl=1 fw_dout=42", s_lvl, f_dout);
        else n_pass++;
        step(1, 0, 0, 1, 0, 0);
        n_checks++;
        if (s_dout !== 8'h42 || s_dv !== 1'b1 || s_emp !== 1'b1)
            $display("FAIL post_flush_rd: dout=%h dv=%b empty=%b want 42 1 1", s_dout, s_dv, s_emp);
        else n_pass++;
    endtask

    task automatic test_random;
        logic we, re, fl, ce;
        step(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 800; c++) begin
            we = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 70 : 35));
            re = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 35 : 70));
            fl = ($urandom_range(0, 99) < 2);
            ce = ($urandom_range(0, 99) < 5);
            step(1, we, 8'($urandom), re, fl, ce);
            n_checks++;
            if (vec_std !== exp_vec(0))
                $display("FAIL rand_std_%0d: got %h want %h", c, vec_std, exp_vec(0));
            else n_pass++;
            n_checks++;
            if (vec_fw !== exp_vec(1))
                $display("FAIL rand_fw_%0d: got %h want %h", c, vec_fw, exp_vec(1));
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; clear_err = 1'b0;
        write_en = 1'b0; read_en = 1'b0; data_in = '0;
        @(negedge clk);
        test_reset;
        test_fill_overflow;
        test_std_read;
        test_fwft;
        test_full_rw;
        test_empty_rw;
        test_flush;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
